led_time_bar_driver: RTL



---
 rtl/led_bar_pkg.sv | 30 +++
 rtl/led_blink_phase_gen.sv | 51 +++++
 rtl/led_time_bar_driver.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/led_bar_pkg.sv
// Shared types, default constants and the thermometer helper for the LED time bar.
// LED_TIME_BAR_BEEP_EN adds the default beep pulse length.
package led_bar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLASH = 2'd2,
        ST_DONE  = 2'd3
    } bar_state_e;

    localparam int DEF_NUM_LEDS     = 10;
    localparam int DEF_TIME_W       = 4;
    localparam int DEF_BLINK_CYCLES = 25000000;
    localparam int DEF_WARN_LEVEL   = 3;
    localparam int DEF_FLASH_COUNT  = 3;
`ifdef LED_TIME_BAR_BEEP_EN
    localparam int DEF_BEEP_CYCLES  = 5000000;
`endif

    // One bar segment: lit when its index is below the level, clamped to the bar width.
    function automatic logic therm_bit(input int unsigned level,
                                       input int unsigned idx,
                                       input int unsigned width);
        int unsigned lim;
        lim = (level < width) ? level : width;
        return logic'(idx < lim);
    endfunction

endpackage

// File: rtl/led_blink_phase_gen.sv
// Free-running blink half-period counter with phase toggle, synchronous clear and
// a raw terminal-count (wrap) flag. Shared by the RUN warning blink and the FLASH sequence.
module led_blink_phase_gen
    import led_bar_pkg::*;
#(
    parameter int BLINK_CYCLES = DEF_BLINK_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic phase_o,
    output logic phase_next_o,
    output logic wrap_o
);

    localparam int CNT_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    // wrap_o is not gated by clr_i so the parent can derive its clear from it without a loop.
    assign wrap_o       = (cnt_q == CNT_MAX);
    assign phase_o      = phase_q;
    assign phase_next_o = phase_d;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        cnt_d   = cnt_q + CNT_W'(1);
        phase_d = phase_q;
        if (clr_i) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (wrap_o) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/led_time_bar_driver.sv
// LED bar thermometer gauge with low-time warning blink and timeout flash sequence.
// Define LED_TIME_BAR_BEEP_EN to add the beep output driven by time decrements and the flash.
module led_time_bar_driver
    import led_bar_pkg::*;
#(
    parameter int NUM_LEDS     = DEF_NUM_LEDS,
    parameter int TIME_W       = DEF_TIME_W,
    parameter int BLINK_CYCLES = DEF_BLINK_CYCLES,
    parameter int WARN_LEVEL   = DEF_WARN_LEVEL,
    parameter int FLASH_COUNT  = DEF_FLASH_COUNT
`ifdef LED_TIME_BAR_BEEP_EN
    ,
    parameter int BEEP_CYCLES  = DEF_BEEP_CYCLES
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [TIME_W-1:0]   time_in,
    input  logic                timeout_in,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                warn,
    output logic                done
`ifdef LED_TIME_BAR_BEEP_EN
    ,
    output logic                beep
`endif
);

    localparam int FC_W = (FLASH_COUNT > 1) ? $clog2(FLASH_COUNT + 1) : 1;
    localparam logic [FC_W-1:0] FLASH_LAST = FC_W'(FLASH_COUNT - 1);

    bar_state_e          state_q, state_d;
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic                warn_q, warn_d;
    logic                done_q, done_d;
    logic [FC_W-1:0]     flash_cnt_q, flash_cnt_d;

    logic [NUM_LEDS-1:0] therm;
    logic                in_warn;
    logic                blink_clr;
    logic                phase, phase_next, wrap;

    always_comb begin
        therm = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            therm[i] = therm_bit(32'(time_in), i, NUM_LEDS);
        end
    end

    assign in_warn   = (time_in != '0) && (int'(time_in) <= WARN_LEVEL);
    assign blink_clr = (state_d != state_q);

    led_blink_phase_gen #(
        .BLINK_CYCLES (BLINK_CYCLES)
    ) u_blink (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (blink_clr),
        .phase_o      (phase),
        .phase_next_o (phase_next),
        .wrap_o       (wrap)
    );

    // Next state and flash pair count; a 1->0 phase wrap closes one on/off pair.
    always_comb begin
        state_d     = state_q;
        flash_cnt_d = flash_cnt_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   if (timeout_in) state_d = ST_FLASH;
                ST_FLASH: begin
                    if (wrap && phase) begin
                        if (flash_cnt_q == FLASH_LAST) state_d = ST_DONE;
                        else                           flash_cnt_d = flash_cnt_q + FC_W'(1);
                    end
                end
                ST_DONE:  state_d = ST_DONE;
                default:  state_d = ST_IDLE;
            endcase
        end
        if ((state_d != ST_FLASH) || (state_q != ST_FLASH)) begin
            flash_cnt_d = '0;
        end
    end

    // Outputs are registered from the state being entered and the phase it will see.
    always_comb begin
        led_d  = '0;
        warn_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            ST_IDLE:  led_d = therm;
            ST_RUN: begin
                warn_d = in_warn;
                led_d  = (in_warn && phase_next) ? '0 : therm;
            end
            ST_FLASH: led_d = phase_next ? '0 : '1;
            ST_DONE:  done_d = 1'b1;
            default:  led_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            led_q       <= '0;
            warn_q      <= 1'b0;
            done_q      <= 1'b0;
            flash_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            led_q       <= led_d;
            warn_q      <= warn_d;
            done_q      <= done_d;
            flash_cnt_q <= flash_cnt_d;
        end
    end

    assign led_out = led_q;
    assign warn    = warn_q;
    assign done    = done_q;

`ifdef LED_TIME_BAR_BEEP_EN
    localparam int BC_W = $clog2(BEEP_CYCLES + 1);

    logic [TIME_W-1:0] prev_time_q;
    logic [BC_W-1:0]   beep_cnt_q, beep_cnt_d;
    logic              beep_q, beep_d;
    logic              time_dec;

    assign time_dec = (time_in < prev_time_q);

    // A decrement (re)loads the pulse length; the pulse lasts while the count is nonzero.
    always_comb begin
        beep_cnt_d = '0;
        beep_d     = 1'b0;
        if (state_d == ST_RUN) begin
            if (time_dec)                beep_cnt_d = BC_W'(BEEP_CYCLES);
            else if (beep_cnt_q != '0)   beep_cnt_d = beep_cnt_q - BC_W'(1);
            beep_d = (beep_cnt_d != '0);
        end else if (state_d == ST_FLASH) begin
            beep_d = led_d[0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_time_q <= '0;
            beep_cnt_q  <= '0;
            beep_q      <= 1'b0;
        end else begin
            prev_time_q <= time_in;
            beep_cnt_q  <= beep_cnt_d;
            beep_q      <= beep_d;
        end
    end

    assign beep = beep_q;
`endif

endmodule
